button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 123 ++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Debounces the raw jump/duck buttons and presents them to the processor as
// frame-coherent requests that change only on VGA frame boundaries.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       screen_end,
    output logic       io_jump,
    output logic       io_duck,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    logic       up_rise;
    logic       duck_level;

    assign raw = {down, up};

    // Index 0 is the jump button, index 1 the duck button.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic                meta_q;
            logic                synced_q;
            db_state_t           state_q;
            logic [CNT_W-1:0]    cnt_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    meta_q   <= 1'b0;
                    synced_q <= 1'b0;
                    state_q  <= STABLE_LO;
                    cnt_q    <= '0;
                end else begin
                    meta_q   <= raw[gi];
                    synced_q <= meta_q;
                    case (state_q)
                        STABLE_LO: begin
                            if (synced_q) begin
                                state_q <= WAIT_HI;
                                cnt_q   <= '0;
                            end
                        end
                        WAIT_HI: begin
                            if (!synced_q)
                                state_q <= STABLE_LO;
                            else if (cnt_q == CNT_LAST)
                                state_q <= STABLE_HI;
                            else
                                cnt_q <= cnt_q + 1'b1;
                        end
                        STABLE_HI: begin
                            if (!synced_q) begin
                                state_q <= WAIT_LO;
                                cnt_q   <= '0;
                            end
                        end
                        WAIT_LO: begin
                            if (synced_q)
                                state_q <= STABLE_HI;
                            else if (cnt_q == CNT_LAST)
                                state_q <= STABLE_LO;
                            else
                                cnt_q <= cnt_q + 1'b1;
                        end
                        default: state_q <= STABLE_LO;
                    endcase
                end
            end

            if (gi == 0) begin : g_rise
                // True on exactly the edge the FSM enters STABLE_HI.
                assign up_rise = (state_q == WAIT_HI) && synced_q && (cnt_q == CNT_LAST);
            end else begin : g_level
                assign duck_level = (state_q == STABLE_HI) || (state_q == WAIT_LO);
            end
        end
    endgenerate

    logic       pending_q, pending_d;
    logic       jump_q;
    logic       duck_q;
    logic [7:0] count_q, count_d;

    // A rise on the frame edge survives the clear so no press is dropped.
    always_comb begin
        pending_d = up_rise | (pending_q & ~screen_end);
        count_d   = count_q + {7'd0, up_rise};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= 1'b0;
            jump_q    <= 1'b0;
            duck_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            if (screen_end) begin
                jump_q <= pending_q;
                duck_q <= duck_level;
            end
        end
    end

    assign io_jump     = jump_q;
    assign io_duck     = duck_q;
    assign press_count = count_q;

endmodule
